// File: rtl/reg_arbiter_pkg.sv
// Shared definitions for the register arbiter: FSM encoding, default sizes
// and the clock period used by benches.
package reg_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CLK_PER   = 10;

  // Index width for NREQ requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg8.sv
// Shared data register with synchronous reset and load enable.
module reg8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (ena) q <= d;
  end

endmodule

// File: rtl/reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr,
// wrapping from the top requester back to 0.
module rr_pick
  import reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = idx_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic [NREQ-1:0] rot;
  logic [IW:0]     sum;
  logic            found;

  // Rotate so that bit j of rot is requester (ptr + j) mod NREQ.
  assign rot     = NREQ'({req, req} >> ptr);
  assign any_req = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(j);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        winner = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared
// register; each transaction runs IDLE -> WRITE -> DONE.
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DIN,
  output logic [NREQ-1:0]       GNT,
  output logic [WIDTH-1:0]      R,
  output logic                  DONE,
  output logic                  BUSY,
  output logic [7:0]            WR_CNT
);

  localparam int unsigned IW = idx_w(NREQ);

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q, win_d, ptr_q, ptr_d, pick;
  logic              any_req;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              ena_q, ena_d;
  logic [WIDTH-1:0]  data_q, data_d, slice;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              reg_rst;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_q == IW'(i)) slice = DIN[i*WIDTH +: WIDTH];
    end
  end

  // Register controls are themselves registered, so R and DONE appear one
  // cycle after the DONE state; GNT therefore spans the WRITE and DONE states.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ena_d   = 1'b0;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ena_d   = 1'b1;
        data_d  = slice;
        state_d = S_DONE;
      end
      S_DONE: begin
        gnt_d   = '0;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        ptr_d   = (win_q == IW'(NREQ-1)) ? '0 : win_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ena_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ena_q   <= ena_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_rst = RST;

  reg8 #(.WIDTH(WIDTH)) u_reg (
    .clk (CLK),
    .rst (reg_rst),
    .ena (ena_q),
    .d   (data_q),
    .q   (R)
  );

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign BUSY   = (state_q != S_IDLE);
  assign WR_CNT = cnt_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Scoreboard bench for reg_arbiter: drivers queue expected writes, a negedge
// monitor checks each DONE pulse against the queue head.
module tb_reg_arbiter;
  import reg_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NR-1:0]   REQ;
  logic [NR*W-1:0] DIN;
  logic [NR-1:0]   GNT;
  logic [W-1:0]    R;
  logic            DONE, BUSY;
  logic [7:0]      WR_CNT;

  reg_arbiter #(.NREQ(NR), .WIDTH(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .DIN    (DIN),
    .GNT    (GNT),
    .R      (R),
    .DONE   (DONE),
    .BUSY   (BUSY),
    .WR_CNT (WR_CNT)
  );

  always #(CLK_PER/2) CLK = ~CLK;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] r;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         pushes = 0;
  int         dones  = 0;
  int         gcyc   = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] last_gnt = 4'd0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input int idx, input logic [7:0] d);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.gnt = 4'b0001 << idx;
    e.r   = d;
    e.cnt = exp_cnt;
    sb.push_back(e);
    pushes++;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      exp_t e;
      chk("busy_vs_gnt", 32'(BUSY), 32'(|GNT));
      chk("gnt_onehot", 32'($onehot0(GNT)), 32'd1);
      if (GNT != '0) begin
        gcyc++;
        last_gnt = GNT;
      end
      if (DONE === 1'b1) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: R=%0h with no write pending", R);
        end else begin
          e = sb.pop_front();
          chk("gnt_winner", 32'(last_gnt), 32'(e.gnt));
          chk("r_value", 32'(R), 32'(e.r));
          chk("wr_cnt", 32'(WR_CNT), 32'(e.cnt));
          chk("gnt_cycles", 32'(gcyc), 32'd2);
        end
        gcyc = 0;
      end else if (GNT == '0) begin
        gcyc = 0;
      end
    end
  end

  task automatic wait_gnt(input logic [3:0] g, input string name);
    int n = 0;
    @(negedge CLK);
    while (GNT !== g && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (GNT !== g) begin
      checks++;
      errors++;
      $display("FAIL timeout_gnt_%s: GNT=%b expected %b", name, GNT, g);
    end
  endtask

  task automatic wait_done(input int cnt, input string name);
    int seen = 0;
    int n = 0;
    while (seen < cnt && n < cnt*10 + 20) begin
      @(negedge CLK);
      n++;
      if (DONE === 1'b1) seen++;
    end
    if (seen < cnt) begin
      checks++;
      errors++;
      $display("FAIL timeout_done_%s: saw %0d expected %0d", name, seen, cnt);
    end
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_empty_%s: %0d writes still pending", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge CLK);
    RST = 1'b1;
    REQ = '0;
    repeat (cycles) @(negedge CLK);
    RST = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic idle_checks(input int n, input string name);
    repeat (n) begin
      @(negedge CLK);
      chk({name, "_r"}, 32'(R), 32'h0);
      chk({name, "_gnt"}, 32'(GNT), 32'h0);
      chk({name, "_busy"}, 32'(BUSY), 32'h0);
      chk({name, "_wr_cnt"}, 32'(WR_CNT), 32'h0);
      chk({name, "_done"}, 32'(DONE), 32'h0);
    end
  endtask

  task automatic do_write(input int idx, input logic [7:0] d);
    DIN[idx*W +: W] = d;
    REQ = 4'b0001 << idx;
    expect_write(idx, d);
    wait_gnt(4'b0001 << idx, "single");
    REQ = '0;
    wait_done(1, "single");
  endtask

  initial begin
    RST = 1'b1;
    REQ = '0;
    DIN = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;

    // Quiet after reset.
    idle_checks(4, "reset");

    // Single write from requester 0.
    do_write(0, 8'hF0);

    // All requesters held: rotation 0,1,2,3,0.
    apply_reset(2);
    DIN = {8'h04, 8'h03, 8'h02, 8'h01};
    REQ = 4'b1111;
    expect_write(0, 8'h01);
    expect_write(1, 8'h02);
    expect_write(2, 8'h03);
    expect_write(3, 8'h04);
    expect_write(0, 8'h01);
    wait_done(5, "rotate");
    REQ = '0;
    wait_empty("rotate");

    // Requests raised during WRITE wait; pointer moves past the winner.
    DIN = {8'h55, 8'h33, 8'h11, 8'h77};
    REQ = 4'b0100;
    expect_write(2, 8'h33);
    expect_write(3, 8'h55);
    expect_write(1, 8'h11);
    wait_gnt(4'b0100, "late_req2");
    REQ = 4'b1010;
    wait_gnt(4'b1000, "late_req3");
    REQ = 4'b0010;
    wait_gnt(4'b0010, "late_req1");
    REQ = '0;
    wait_empty("late");

    // Reset during WRITE aborts and restarts arbitration at requester 0.
    DIN = {8'h00, 8'h00, 8'h00, 8'hFF};
    REQ = 4'b0001;
    wait_gnt(4'b0001, "abort");
    RST = 1'b1;
    REQ = '0;
    @(negedge CLK);
    RST = 1'b0;
    exp_cnt = 8'd0;
    idle_checks(3, "abort");
    DIN = {8'h5A, 8'h00, 8'h00, 8'hA5};
    REQ = 4'b1001;
    expect_write(0, 8'hA5);
    expect_write(3, 8'h5A);
    wait_gnt(4'b0001, "post_abort0");
    REQ = 4'b1000;
    wait_gnt(4'b1000, "post_abort3");
    REQ = '0;
    wait_empty("post_abort");

    // 256 writes wrap the counter back to zero.
    apply_reset(2);
    dones  = 0;
    pushes = 0;
    for (int i = 0; i < 256; i++) begin
      do_write(0, 8'(i));
    end
    wait_empty("wrap");
    @(negedge CLK);
    chk("wrap_wr_cnt", 32'(WR_CNT), 32'h0);
    chk("wrap_done_count", 32'(dones), 32'd256);

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_vs_push", 32'(dones), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the register.
REQ-002 Parameter WIDTH, default 8, data width of the shared register.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ  input  NREQ  per-requester write request, level; bit i belongs to requester i.
REQ-006 DIN  input  NREQ*WIDTH  flat write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 GNT  output  NREQ  one-hot grant, registered; all zero when nothing is granted.
REQ-008 R  output  WIDTH  current contents of the shared register.
REQ-009 DONE  output  1  one-cycle pulse; R holds the newly written value.
REQ-010 BUSY  output  1  high whenever state is not IDLE.
REQ-011 WR_CNT  output  8  count of completed writes, wraps 255->0.

Function
REQ-012 FSM states: IDLE, WRITE, DONE; each state other than IDLE lasts exactly one cycle.
REQ-013 IDLE: if any REQ bit is high, latch winner index, set GNT one-hot to winner, go to WRITE; otherwise stay in IDLE with GNT=0.
REQ-014 Winner: round-robin; first asserted REQ bit at or above pointer PTR, wrapping NREQ-1 -> 0.
REQ-015 WRITE: GNT stays asserted; register ENA=1; register DATA = DIN slice of the latched winner; R updates at the end of this cycle; next state DONE.
REQ-016 DONE: GNT=0; DONE=1; WR_CNT increments by 1 (8-bit wrap); PTR = (winner+1) mod NREQ; next state IDLE.
REQ-017 Arbitration is suppressed in WRITE and DONE; REQ changes in those states do not affect the current transaction.
REQ-018 Handshake: requester holds REQ and DIN stable until it sees GNT, then drops REQ by the DONE cycle; a REQ still high in the following IDLE counts as a new request.
REQ-019 Latency: REQ sampled high in IDLE at edge N -> GNT high in cycles N+1 and N+2 -> R valid and DONE=1 in cycle N+3; one write per 3 cycles at most.
REQ-020 Register ENA=0 in IDLE and DONE; R holds its value between writes.
REQ-021 DIN of non-granted requesters never reaches R.
REQ-022 With all REQ bits high continuously, grants rotate 0,1,2,3,0,...; no requester waits more than NREQ transactions.

Reset
REQ-023 RST high at a rising edge -> state IDLE, GNT=0, R=0, DONE=0, BUSY=0, WR_CNT=0, PTR=0.
REQ-024 RST has priority over everything in every state; RST during WRITE aborts the write (R=0, no DONE, WR_CNT unchanged from 0).
REQ-025 First arbitration after RST deasserts starts from PTR=0.

Structure
REQ-026 Shared package/definitions file holds the state encoding constants (IDLE, WRITE, DONE), the default NREQ/WIDTH, and the CLK_PER used by benches.
REQ-027 Shared register is an instance of the team's existing 8-bit register module, driven by CLK, a reset derived from RST, ENA and the muxed DATA.
REQ-028 One sub-module, rr_pick, is natural: combinational round-robin selector (REQ, PTR -> winner index, any_req).

Verification
REQ-029 RST=1 two cycles, then REQ=0 -> R=00, GNT=0000, BUSY=0, WR_CNT=0 indefinitely.
REQ-030 REQ=0001, DIN[7:0]=F0 -> GNT=0001 in the next two cycles, then DONE=1, R=F0, WR_CNT=1.
REQ-031 REQ=1111 held, DIN slices 01,02,03,04 -> GNT order 0001,0010,0100,1000,0001; R sequence 01,02,03,04,01.
REQ-032 REQ=0100 then REQ=1010 raised during WRITE -> first write R=slice2, then requester 3 is granted (PTR=3), then requester 1.
REQ-033 RST pulsed during WRITE with DIN=FF -> R=00, GNT=0000, no DONE, WR_CNT=0, next grant from requester 0.
REQ-034 256 single writes by requester 0 -> WR_CNT wraps to 0; DONE pulses exactly 256 times.
